// File: rtl/instr_port_arbiter.sv
// Round-robin arbiter that shares one instruction-memory port between two
// fetch requesters (0: IF prefetch buffer, 1: secondary fetcher).
// A pending, ungranted request locks the selection so the address and owner
// cannot change under it. An in-order owner FIFO steers each response back
// to the requester that issued the matching transfer.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   m0_* / m1_*                    requester req/addr in, gnt/rvalid/rdata out
//   instr_req_o/addr_o/gnt_i       memory request channel
//   instr_rvalid_i/rdata_i         memory response channel
//   busy_o                         transfers outstanding or lock held
//   err_o                          response arrived with no owner recorded
module instr_port_arbiter #(
   parameter int unsigned RDATA_WIDTH     = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   m0_req_i,
   input  logic [31:0]            m0_addr_i,
   output logic                   m0_gnt_o,
   output logic                   m0_rvalid_o,
   output logic [RDATA_WIDTH-1:0] m0_rdata_o,
   input  logic                   m1_req_i,
   input  logic [31:0]            m1_addr_i,
   output logic                   m1_gnt_o,
   output logic                   m1_rvalid_o,
   output logic [RDATA_WIDTH-1:0] m1_rdata_o,
   output logic                   instr_req_o,
   output logic [31:0]            instr_addr_o,
   input  logic                   instr_gnt_i,
   input  logic                   instr_rvalid_i,
   input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic                       prio_q;
   logic                       lock_q;
   logic                       lock_id_q;
   logic [MAX_OUTSTANDING-1:0] fifo_q;
   logic [PTR_W-1:0]           wr_ptr_q;
   logic [PTR_W-1:0]           rd_ptr_q;
   logic [CNT_W-1:0]           count_q;

   logic sel;
   logic sel_req;
   logic empty;
   logic full;
   logic accept;
   logic pop;
   logic head;

   // Wrap-around increment for non-power-of-two depths
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Selection, memory request and response steering (no pipeline stage)
   always_comb begin
      sel          = prio_q;
      sel_req      = 1'b0;
      empty        = 1'b0;
      full         = 1'b0;
      accept       = 1'b0;
      pop          = 1'b0;
      head         = 1'b0;
      instr_req_o  = 1'b0;
      instr_addr_o = m0_addr_i;
      m0_gnt_o     = 1'b0;
      m1_gnt_o     = 1'b0;
      m0_rvalid_o  = 1'b0;
      m1_rvalid_o  = 1'b0;
      err_o        = 1'b0;
      busy_o       = 1'b0;

      if (lock_q)
         sel = lock_id_q;
      else if (m0_req_i ^ m1_req_i)
         sel = m1_req_i;

      sel_req = sel ? m1_req_i : m0_req_i;
      empty   = (count_q == '0);
      // A same-cycle response frees a slot, so a full FIFO need not stall
      full    = (count_q == CNT_MAX) && !instr_rvalid_i;

      instr_req_o  = sel_req && !full;
      instr_addr_o = sel ? m1_addr_i : m0_addr_i;
      accept       = instr_req_o && instr_gnt_i;
      m0_gnt_o     = accept && !sel;
      m1_gnt_o     = accept && sel;

      pop         = instr_rvalid_i && !empty;
      head        = fifo_q[rd_ptr_q];
      m0_rvalid_o = pop && !head;
      m1_rvalid_o = pop && head;
      err_o       = instr_rvalid_i && empty;
      busy_o      = !empty || lock_q;
   end

   assign m0_rdata_o = instr_rdata_i;
   assign m1_rdata_o = instr_rdata_i;

   // Arbitration state: round-robin pointer and request lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q    <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
      end else if (accept) begin
         prio_q <= ~sel;
         lock_q <= 1'b0;
      end else if (instr_req_o) begin
         lock_q    <= 1'b1;
         lock_id_q <= sel;
      end
   end

   // Owner FIFO: one id bit per outstanding transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            fifo_q[wr_ptr_q] <= sel;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({accept, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_port_arbiter.sv
// Testbench for instr_port_arbiter: directed vector table, hand-written
// reset corner case, and a randomized run against a queue-based model.
module tb_instr_port_arbiter;

   localparam int unsigned RW   = 32;
   localparam int unsigned MAXO = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_req_i, m1_req_i;
   logic [31:0]   m0_addr_i, m1_addr_i;
   logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [RW-1:0] m0_rdata_o, m1_rdata_o;
   logic          instr_req_o;
   logic [31:0]   instr_addr_o;
   logic          instr_gnt_i, instr_rvalid_i;
   logic [RW-1:0] instr_rdata_i;
   logic          busy_o, err_o;

   instr_port_arbiter #(.RDATA_WIDTH(RW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        rst;
      logic        r0;
      logic [31:0] a0;
      logic        r1;
      logic [31:0] a1;
      logic        gnt;
      logic        rv;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_g0;
      logic        e_g1;
      logic        e_rv0;
      logic        e_rv1;
      logic        e_err;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic r0, input logic [31:0] a0,
                               input logic r1, input logic [31:0] a1, input logic gnt,
                               input logic rv, input logic e_req, input logic [31:0] e_addr,
                               input logic e_g0, input logic e_g1, input logic e_rv0,
                               input logic e_rv1, input logic e_err, input logic e_busy);
      vec_t v;
      v = '{rst, r0, a0, r1, a1, gnt, rv, e_req, e_addr, e_g0, e_g1, e_rv0, e_rv1, e_err, e_busy};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r0, input logic [31:0] a0, input logic r1,
                        input logic [31:0] a1, input logic g, input logic rv,
                        input logic [RW-1:0] rd);
      m0_req_i = r0; m0_addr_i = a0; m1_req_i = r1; m1_addr_i = a1;
      instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd;
   endtask

   // Reset asserted mid-cycle, released 1 time unit after a rising edge
   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_g0, input logic e_g1, input logic e_rv0,
                            input logic e_rv1, input logic e_err, input logic e_busy,
                            input logic [RW-1:0] e_rd);
      chk({tag, ".req"},    32'(instr_req_o), 32'(e_req));
      chk({tag, ".addr"},   instr_addr_o,     e_addr);
      chk({tag, ".gnt0"},   32'(m0_gnt_o),    32'(e_g0));
      chk({tag, ".gnt1"},   32'(m1_gnt_o),    32'(e_g1));
      chk({tag, ".rv0"},    32'(m0_rvalid_o), 32'(e_rv0));
      chk({tag, ".rv1"},    32'(m1_rvalid_o), 32'(e_rv1));
      chk({tag, ".err"},    32'(err_o),       32'(e_err));
      chk({tag, ".busy"},   32'(busy_o),      32'(e_busy));
      chk({tag, ".rdata0"}, 32'(m0_rdata_o),  32'(e_rd));
      chk({tag, ".rdata1"}, 32'(m1_rdata_o),  32'(e_rd));
   endtask

   // Inputs change 1 unit after posedge, outputs checked 2 units later
   task automatic run_vec(input vec_t v, input int idx);
      logic [RW-1:0] rd;
      if (v.rst) do_reset();
      rd = RW'(32'hC0DE_0000 + 32'(idx));
      drive(v.r0, v.a0, v.r1, v.a1, v.gnt, v.rv, rd);
      #2;
      check_all($sformatf("vec%0d", idx), v.e_req, v.e_addr, v.e_g0, v.e_g1,
                v.e_rv0, v.e_rv1, v.e_err, v.e_busy, rd);
      @(posedge clk);
      #1;
   endtask

   // Reference model: round-robin owner, lock and an in-order owner queue
   bit m_prio, m_lock, m_lid;
   bit m_q[$];

   initial begin
      logic          p0, p1, sel, acc, e_req, e_g0, e_g1, e_rv0, e_rv1, e_err, e_busy, full, rv, g;
      logic [31:0]   a0, a1, e_addr;
      logic [RW-1:0] rd;

      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
      #2 rst_n = 1'b0;
      #1;
      check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single requester stream
      vecs.push_back(mk(1,1,32'h80,0,32'h0,1,0, 1,32'h80, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,32'h84,0,32'h0,1,1, 1,32'h84, 1,0,1,0,0,1));
      vecs.push_back(mk(0,1,32'h88,0,32'h0,1,1, 1,32'h88, 1,0,1,0,0,1));
      vecs.push_back(mk(0,0,32'h88,0,32'h0,0,1, 0,32'h0,  0,0,1,0,0,1));
      vecs.push_back(mk(0,0,32'h88,0,32'h0,0,0, 0,32'h0,  0,0,0,0,0,0));
      // contention with instant grants
      vecs.push_back(mk(1,1,32'h200,1,32'h300,1,0, 1,32'h200, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,32'h200,1,32'h300,1,1, 1,32'h300, 0,1,1,0,0,1));
      vecs.push_back(mk(0,1,32'h200,1,32'h300,1,1, 1,32'h200, 1,0,0,1,0,1));
      vecs.push_back(mk(0,1,32'h200,1,32'h300,1,1, 1,32'h300, 0,1,1,0,0,1));
      vecs.push_back(mk(0,0,32'h200,0,32'h300,0,1, 0,32'h200, 0,0,0,1,0,1));
      vecs.push_back(mk(0,0,32'h200,0,32'h300,0,0, 0,32'h200, 0,0,0,0,0,0));
      // lock: prio points at m1, yet pending m0 keeps the port
      vecs.push_back(mk(0,1,32'h40, 0,32'h300,1,0, 1,32'h40,  1,0,0,0,0,0));
      vecs.push_back(mk(0,1,32'h100,0,32'h300,0,1, 1,32'h100, 0,0,1,0,0,1));
      vecs.push_back(mk(0,1,32'h100,1,32'h300,0,0, 1,32'h100, 0,0,0,0,0,1));
      vecs.push_back(mk(0,1,32'h100,1,32'h300,0,0, 1,32'h100, 0,0,0,0,0,1));
      vecs.push_back(mk(0,1,32'h100,1,32'h300,1,0, 1,32'h100, 1,0,0,0,0,1));
      vecs.push_back(mk(0,0,32'h100,1,32'h300,1,1, 1,32'h300, 0,1,1,0,0,1));
      vecs.push_back(mk(0,0,32'h100,0,32'h300,0,1, 0,32'h100, 0,0,0,1,0,1));
      vecs.push_back(mk(0,0,32'h100,0,32'h300,0,0, 0,32'h100, 0,0,0,0,0,0));
      // full: third request stalls, then proceeds alongside a response
      vecs.push_back(mk(1,1,32'h10,0,32'h0,1,0, 1,32'h10, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,32'h14,0,32'h0,1,0, 1,32'h14, 1,0,0,0,0,1));
      vecs.push_back(mk(0,1,32'h18,0,32'h0,1,0, 0,32'h18, 0,0,0,0,0,1));
      vecs.push_back(mk(0,1,32'h18,0,32'h0,1,1, 1,32'h18, 1,0,1,0,0,1));
      vecs.push_back(mk(0,0,32'h18,0,32'h0,0,1, 0,32'h0,  0,0,1,0,0,1));
      vecs.push_back(mk(0,0,32'h18,0,32'h0,0,1, 0,32'h0,  0,0,1,0,0,1));
      vecs.push_back(mk(0,0,32'h18,0,32'h0,0,1, 0,32'h0,  0,0,0,0,1,0));
      vecs.push_back(mk(0,0,32'h18,0,32'h0,0,0, 0,32'h0,  0,0,0,0,0,0));
      // spurious response leaves the FIFO empty
      vecs.push_back(mk(1,0,32'h0,0,32'h0, 0,1, 0,32'h0,  0,0,0,0,1,0));
      vecs.push_back(mk(0,0,32'h0,0,32'h0, 0,0, 0,32'h0,  0,0,0,0,0,0));
      vecs.push_back(mk(0,0,32'h0,1,32'h20,1,0, 1,32'h20, 0,1,0,0,0,0));
      vecs.push_back(mk(0,0,32'h0,0,32'h20,0,1, 0,32'h0,  0,0,0,1,0,1));
      vecs.push_back(mk(0,0,32'h0,0,32'h20,0,1, 0,32'h0,  0,0,0,0,1,0));

      foreach (vecs[i]) run_vec(vecs[i], i);

      // reset with two transfers outstanding
      do_reset();
      drive(1'b1, 32'h500, 1'b0, 32'h600, 1'b1, 1'b0, '0);
      #2 chk("rst_mid.gnt0", 32'(m0_gnt_o), 32'd1);
      @(posedge clk); #1;
      drive(1'b0, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, '0);
      #2 chk("rst_mid.gnt1", 32'(m1_gnt_o), 32'd1);
      @(posedge clk); #1;
      drive(1'b0, 32'h500, 1'b0, 32'h600, 1'b0, 1'b0, '0);
      #2 chk("rst_mid.busy_pre", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all("rst_mid.in", 1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #2 chk("rst_mid.busy_post", 32'(busy_o), 32'd0);
      instr_rvalid_i = 1'b1;
      #1;
      chk("rst_mid.late_err", 32'(err_o),       32'd1);
      chk("rst_mid.late_rv0", 32'(m0_rvalid_o), 32'd0);
      chk("rst_mid.late_rv1", 32'(m1_rvalid_o), 32'd0);
      @(posedge clk); #1;

      // randomized traffic against the reference model
      do_reset();
      m_prio = 1'b0; m_lock = 1'b0; m_lid = 1'b0; m_q.delete();
      p0 = 1'b0; p1 = 1'b0; a0 = 32'h0; a1 = 32'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1'b1; a0 = $urandom() & 32'hFFFF_FFFC; end
         if (!p1 && $urandom_range(0, 3) == 0) begin p1 = 1'b1; a1 = $urandom() & 32'hFFFF_FFFC; end
         g  = ($urandom_range(0, 9) < 6);
         rv = (m_q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
         rd = RW'($urandom());
         drive(p0, a0, p1, a1, g, rv, rd);
         #2;
         sel    = m_lock ? m_lid : ((p0 != p1) ? p1 : m_prio);
         full   = (m_q.size() == MAXO) && !rv;
         e_req  = (sel ? p1 : p0) && !full;
         e_addr = sel ? a1 : a0;
         acc    = e_req && g;
         e_g0   = acc && !sel;
         e_g1   = acc && sel;
         e_rv0  = rv && (m_q.size() != 0) && (m_q[0] == 1'b0);
         e_rv1  = rv && (m_q.size() != 0) && (m_q[0] == 1'b1);
         e_err  = rv && (m_q.size() == 0);
         e_busy = (m_q.size() != 0) || m_lock;
         check_all($sformatf("rnd%0d", cyc), e_req, e_addr, e_g0, e_g1,
                   e_rv0, e_rv1, e_err, e_busy, rd);
         @(posedge clk); #1;
         if (rv && m_q.size() != 0) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back(sel);
            m_prio = !sel;
            m_lock = 1'b0;
         end else if (e_req) begin
            m_lock = 1'b1;
            m_lid  = sel;
         end
         if (e_g0) p0 = 1'b0;
         if (e_g1) p1 = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
